// File: rtl/bs_pkg.sv
// bs_pkg: shared definitions for the bit-serial MAC transmit side and its MAC partner.
//   PREC_8/PREC_4/PREC_2 (PREC_4A is the 2'b11 alias of PREC_4)
//   state_t  streamer FSM states
//   word_t   one parallel {act, wgt, prec} word
//   prec_nbits(prec) -> N (8/4/2), modmask(prec) -> N-1, used as cnt & mask == cnt mod N
package bs_pkg;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {PREC_8 = 2'b00, PREC_4 = 2'b01, PREC_2 = 2'b10, PREC_4A = 2'b11} prec_t;
    typedef enum logic [1:0] {IDLE, STREAM, ALIGN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] act;
        logic [DATA_W-1:0] wgt;
        logic [1:0]        prec;
    } word_t;

    function automatic logic [3:0] prec_nbits(input logic [1:0] p);
        return (p == PREC_8) ? 4'd8 : (p == PREC_2) ? 4'd2 : 4'd4;
    endfunction

    function automatic logic [CNT_W-1:0] modmask(input logic [1:0] p);
        return CNT_W'(prec_nbits(p) - 4'd1);
    endfunction
endpackage

// File: rtl/bitserial_weight_streamer_if.sv
// bitserial_weight_streamer_if: word handshake and bit-serial MAC bus of the streamer.
//   upstream : in_valid, in_ready, in_act, in_wgt, in_prec
//   MAC side : mac_ready, bs_en, bs_act, bs_wbit, bs_prec, bs_first, bs_last, prod_valid
//   status   : busy
//   modport slave  = the streamer, modport master = the word producer / MAC environment
interface bitserial_weight_streamer_if;
    import bs_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_act;
    logic [DATA_W-1:0] in_wgt;
    logic [1:0]        in_prec;
    logic              mac_ready;
    logic              bs_en;
    logic [DATA_W-1:0] bs_act;
    logic              bs_wbit;
    logic [1:0]        bs_prec;
    logic              bs_first;
    logic              bs_last;
    logic              prod_valid;
    logic              busy;

    modport slave (
        input  in_valid, in_act, in_wgt, in_prec, mac_ready,
        output in_ready, bs_en, bs_act, bs_wbit, bs_prec, bs_first, bs_last, prod_valid, busy
    );
    modport master (
        output in_valid, in_act, in_wgt, in_prec, mac_ready,
        input  in_ready, bs_en, bs_act, bs_wbit, bs_prec, bs_first, bs_last, prod_valid, busy
    );
endinterface

// File: rtl/bs_pend_buf.sv
// bs_pend_buf: one-entry valid/ready holding register for {act, wgt, prec}.
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake; in_ready = ~out_valid (registered, no comb path)
//   in_word              word to park
//   pop                  consumer takes out_word this cycle (only while out_valid)
//   out_valid/out_word   parked word
module bs_pend_buf
    import bs_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  in_valid,
    output logic  in_ready,
    input  word_t in_word,
    input  logic  pop,
    output logic  out_valid,
    output word_t out_word
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (in_valid && !out_valid) begin
            out_valid <= 1'b1;
            out_word  <= in_word;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    assign in_ready = ~out_valid;
endmodule

// File: rtl/bitserial_weight_streamer.sv
// bitserial_weight_streamer: shifts parallel weights out LSB first to a bit-serial MAC.
//   clk, rstn   clock, asynchronous active-low reset (shared with the MAC counter)
//   bus         bitserial_weight_streamer_if.slave: word handshake in, bit-serial bus out
//   stat_words, stat_align (only with BSTX_STATS_EN defined): saturating counts of
//               completed data words and issued align bits
// The word in cur is the one being aligned or streamed; it is loaded from the pending
// buffer at a word boundary, so bs_act/bs_prec only change there.
module bitserial_weight_streamer
    import bs_pkg::*;
(
    input logic clk,
    input logic rstn,
    bitserial_weight_streamer_if.slave bus
`ifdef BSTX_STATS_EN
    ,
    output logic [15:0] stat_words,
    output logic [15:0] stat_align
`endif
);
    state_t           state, state_n;
    word_t            cur, pend_word, in_word;
    logic             pend_valid, load, issue, is_last, prod_q;
    logic [CNT_W-1:0] cnt, cnt_inc, cm, pm, idx;

    assign in_word = {bus.in_act, bus.in_wgt, (bus.in_prec == PREC_4A) ? PREC_4 : bus.in_prec};

    bs_pend_buf u_pend (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_word   (in_word),
        .pop       (load),
        .out_valid (pend_valid),
        .out_word  (pend_word)
    );

    assign cm      = modmask(cur.prec);
    assign pm      = modmask(pend_word.prec);
    assign idx     = cnt & cm;
    assign cnt_inc = cnt + 1'b1;
    assign issue   = (state != IDLE) && bus.mac_ready;
    assign is_last = (state == STREAM) && (idx == cm);

    // A new word streams directly only if its N divides the count it starts at;
    // otherwise zero bits are issued until the MAC counter reaches a multiple of N.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: if (pend_valid) begin
                load    = 1'b1;
                state_n = ((cnt & pm) == '0) ? STREAM : ALIGN;
            end
            STREAM: if (issue && is_last) begin
                load    = pend_valid;
                state_n = !pend_valid ? IDLE : ((cnt_inc & pm) == '0) ? STREAM : ALIGN;
            end
            ALIGN: if (issue && ((cnt_inc & cm) == '0)) state_n = STREAM;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            cur    <= '0;
            prod_q <= 1'b0;
        end else begin
            state  <= state_n;
            prod_q <= issue && is_last;
            if (issue) cnt <= cnt_inc;
            if (load) cur <= pend_word;
        end
    end

    assign bus.bs_en      = issue;
    assign bus.bs_act     = cur.act;
    assign bus.bs_wbit    = (state == STREAM) && cur.wgt[idx];
    assign bus.bs_prec    = cur.prec;
    assign bus.bs_first   = (state == STREAM) && (idx == '0);
    assign bus.bs_last    = is_last;
    assign bus.prod_valid = prod_q;
    assign bus.busy       = (state != IDLE) || pend_valid;

`ifdef BSTX_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_words <= '0;
            stat_align <= '0;
        end else begin
            if (issue && is_last && stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
            if (issue && state == ALIGN && stat_align != 16'hFFFF) stat_align <= stat_align + 16'd1;
        end
    end
`endif
endmodule
